// File: rtl/bcd_display_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) with
// seven-segment rendering, optional leading-zero blanking and overflow dashes.
module bcd_display_seq #(
   parameter int WIDTH    = 10,
   parameter int DIGITS   = 4,
   parameter int BLANK_LZ = 1
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      bin,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   hex,
   output logic [1:0]            dbg_state
);

   // Scratch digit count: enough decimal digits for any WIDTH-bit value.
   localparam int NS = (WIDTH + 2) / 3;
   localparam int XD = (DIGITS > NS) ? DIGITS : NS;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Handshake: start is taken on any rising edge where busy=0 (IDLE or DONE);
   // busy covers exactly the WIDTH shift cycles and done marks the result cycle.
   state_t              state;
   logic [WIDTH-1:0]    shreg;
   logic [4*NS-1:0]     scratch;
   logic [4*NS-1:0]     scratch_adj;
   logic [4*NS-1:0]     scratch_nxt;
   logic [CW-1:0]       iter;
   logic [4*XD-1:0]     result_ext;
   logic [4*DIGITS-1:0] bcd_nxt;
   logic                ovf_nxt;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Scans from the top digit down; digit 0 is never blanked.
   function automatic logic [7*DIGITS-1:0] render(input logic [4*DIGITS-1:0] v,
                                                  input logic ovf);
      logic [7*DIGITS-1:0] r;
      logic                seen;
      logic [3:0]          d;
      r    = '0;
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         d = v[4*i +: 4];
         if (d != 4'd0) seen = 1'b1;
         if (ovf)
            r[7*i +: 7] = SEG_DASH;
         else if ((BLANK_LZ != 0) && !seen && (i != 0))
            r[7*i +: 7] = SEG_BLANK;
         else
            r[7*i +: 7] = seg7(d);
      end
      return r;
   endfunction

   always_comb begin
      scratch_adj = scratch;
      for (int i = 0; i < NS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
      scratch_nxt = {scratch_adj[4*NS-2:0], shreg[WIDTH-1]};
   end

   always_comb begin
      result_ext              = '0;
      result_ext[4*NS-1:0]    = scratch_nxt;
      bcd_nxt                 = result_ext[4*DIGITS-1:0];
   end

   // Only digits beyond the displayed ones can flag overflow.
   always_comb begin
      ovf_nxt = 1'b0;
      for (int i = DIGITS; i < XD; i++)
         ovf_nxt = ovf_nxt | (|result_ext[4*i +: 4]);
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         bcd      <= '0;
         hex      <= render('0, 1'b0);
         shreg    <= '0;
         scratch  <= '0;
         iter     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state   <= SHIFT;
                  busy    <= 1'b1;
                  shreg   <= bin;
                  scratch <= '0;
                  iter    <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               scratch <= scratch_nxt;
               shreg   <= {shreg[WIDTH-2:0], 1'b0};
               iter    <= iter + CW'(1);
               // Final iteration: publish the freshly computed result directly.
               if (iter == CW'(WIDTH - 1)) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  bcd      <= bcd_nxt;
                  overflow <= ovf_nxt;
                  hex      <= render(bcd_nxt, ovf_nxt);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state = state;

endmodule
